keypad_scan_4x4: RTL and testbench
==================================

Name: keypad_scan_4x4

Overview:
- Upstream feeder for the car controller's password/mode-select stage.
- Scans a 4x4 matrix keypad and debounces key presses and releases.
- Produces the 4-bit key code `kb_out` used by the controller: 0–9 digits, 4'ha to start entry, 4'hb to clear, 4'hc to confirm, 4'hf when no key is pressed.
- `kb_out` holds the code for the whole time the key stays pressed. The consumer relies on this level behaviour for its own edge filtering.

Parameters:
- CLK_DIV, 50000, clk cycles per scan tick (1 kHz at 50 MHz); legal range ≥2.
- DEBOUNCE_CNT, 20, consecutive ticks of a stable level needed to accept a press or a release; legal range ≥1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- col_in, input, 4, keypad columns; active-low, externally pulled up, asynchronous to clk.
- row_out, output, 4, keypad row drive; exactly one bit low, all others high.
- kb_out, output, 4, debounced key code; 4'hf when idle.
- key_valid, output, 1, one-clk pulse when a new press is accepted.
- key_held, output, 1, high from press acceptance until release acceptance.

Behaviour:
- Synchronizer: `col_in` passes through a 2-FF synchronizer (reset value 4'hf). All decisions use the synchronized value `col_s`.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - `tick` is high for one clk when the counter equals CLK_DIV-1.
  - State advances only on `tick`, except that `key_valid` deasserts on the next clk.
- Row index r (0..3): `row_out` = ~(4'b0001 << r).
  - r changes only on a tick, so each row's drive settles for one full tick before `col_s` is sampled.
- Column decode on each tick:
  - "single": exactly one bit of `col_s` is low; c = index of that bit.
  - "none": `col_s` == 4'hf.
  - "multi": any other value. Multi is treated as none.
- Key map, code = f(r,c):
  - r0: 1, 2, 3, a
  - r1: 4, 5, 6, b
  - r2: 7, 8, 9, c
  - r3: e, 0, d, and col3 is reserved.
  - The reserved key (r3,c3) is treated as none.
- States:
  - SCAN:
    - On tick with single (non-reserved): latch (r,c), cnt←1, go to PRESS_DB. If DEBOUNCE_CNT=1, go directly to PRESSED with the accept actions below.
    - On tick otherwise: r←(r+1) mod 4.
  - PRESS_DB (r held):
    - On tick with single and the same c: cnt←cnt+1.
    - When cnt reaches DEBOUNCE_CNT: go to PRESSED, kb_out←code, key_held←1, key_valid=1 for one clk.
    - On tick with anything else: cnt←0, return to SCAN with r←(r+1) mod 4.
  - PRESSED (r held, kb_out held):
    - On tick with none or multi: cnt←1, go to REL_DB.
    - Otherwise stay.
  - REL_DB:
    - On tick with none: cnt←cnt+1.
    - When cnt reaches DEBOUNCE_CNT: kb_out←4'hf, key_held←0, r←(r+1) mod 4, go to SCAN.
    - On tick with any low column: cnt←0, return to PRESSED. No new key_valid is issued.
- Second key pressed while one is held:
  - Other rows are not scanned, so a key in another row is ignored.
  - A key in the same row gives multi, which starts release debounce. If the original key stays down, the state returns to PRESSED.
- Press latency: at most 4 ticks to reach the row, plus DEBOUNCE_CNT ticks, plus 2 clk for synchronization.
- Reset values (taking effect on the next clk edge while reset=1):
  - row_out=4'b1110, kb_out=4'hf, key_valid=0, key_held=0.
  - State SCAN, r=0, cnt=0, tick counter=0.
  - Reset mid-press forces idle. A key still held after reset is re-detected and produces a fresh key_valid.
- cnt width: $clog2(DEBOUNCE_CNT+1). cnt never exceeds DEBOUNCE_CNT.

Test Plan (CLK_DIV=4, DEBOUNCE_CNT=3):
- Reset with no key pressed: row_out cycles 1110→1101→1011→0111→1110, one step every 4 clk. kb_out=4'hf and key_valid=0 throughout.
- Hold col_in=4'b1101 only while row_out=4'b1011 (key r2,c1 = '8'):
  - kb_out=4'h8 and key_held=1 within 3 ticks + 2 clk of the row becoming active.
  - key_valid goes high exactly once, for one clk.
- Bounce on key '5': toggle the column every tick for 4 ticks, then hold for 5 ticks.
  - No accept during the toggling.
  - A single key_valid with kb_out=4'h5 after the hold.
- Release bounce: after '5' is accepted, release for 2 ticks, press for 1 tick, then release for 3 ticks.
  - kb_out stays 4'h5 until the final 3-tick release, then becomes 4'hf.
  - No second key_valid.
- Press (r0,c3) and (r0,c0) together: multi, so no accept and kb_out stays 4'hf. Press reserved key (r3,c3): kb_out stays 4'hf.
- Sequence a,2,0,1,8,c, each held 5 ticks and released 5 ticks:
  - kb_out shows a,2,0,1,8,c in order, with 4'hf between keys.
  - key_valid pulses 6 times.
  - Assert reset while '8' is held: kb_out=4'hf and key_held=0 on the next clk.

Source files
------------

// File: rtl/keypad_scan_4x4.sv
`timescale 1ns/1ps
// keypad_scan_4x4
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases,
//   and presents a level key code to the password/mode-select controller.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   col_in     keypad columns, active-low, pulled up, asynchronous to clk
//   row_out    row drive, exactly one bit low
//   kb_out     debounced key code (0-9, a=start, b=clear, c=confirm,
//              d/e extra keys), 4'hf when no key is held
//   key_valid  one-clk pulse when a new press is accepted
//   key_held   high from press acceptance until release acceptance
module keypad_scan_4x4 #(
  parameter int CLK_DIV      = 50000,  // clk cycles per scan tick, >= 2
  parameter int DEBOUNCE_CNT = 20      // stable ticks to accept, >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] kb_out,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

  // With a one-tick debounce the first sighting of a key (or of its
  // release) is already the accepting one, so the *_DB states are skipped.
  localparam bit SINGLE_TICK = (DEBOUNCE_CNT == 1);

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    PRESSED,
    REL_DB
  } state_t;

  state_t           state;
  logic [3:0]       col_meta;
  logic [3:0]       col_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       row_idx;
  logic [1:0]       row_next;
  logic [1:0]       col_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic             col_none;
  logic             col_single;
  logic [1:0]       col_idx;
  logic             key_hit;
  logic             same_col;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Key map; (r3,c3) is reserved and reads as "no key".
  function automatic logic [3:0] key_code(input logic [1:0] r,
                                          input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'ha;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hb;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hc;
      4'b11_00: code = 4'he;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hd;
      default:  code = 4'hf;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; idle level (all high) out of reset so the
  // decoder never sees a phantom key.
  // NOTE: sequential state is always assigned with <= so every flop samples
  //       the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta <= 4'hf;
      col_s    <= 4'hf;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  // Scan tick: one clk in CLK_DIV.
  always_ff @(posedge clk) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // Column decode: exactly one low bit is a key; all-high is none;
  // anything else (several keys in the row) is treated as none.
  // NOTE: every output of this block gets a default first, so no path
  //       leaves one unassigned and no latch is inferred.
  always_comb begin
    col_none   = (col_s == 4'hf);
    col_single = 1'b0;
    col_idx    = 2'd0;
    case (col_s)
      4'b1110: begin col_single = 1'b1; col_idx = 2'd0; end
      4'b1101: begin col_single = 1'b1; col_idx = 2'd1; end
      4'b1011: begin col_single = 1'b1; col_idx = 2'd2; end
      4'b0111: begin col_single = 1'b1; col_idx = 2'd3; end
      default: ;
    endcase
  end

  assign key_hit  = col_single && !((row_idx == 2'd3) && (col_idx == 2'd3));
  assign same_col = col_single && (col_idx == col_q);
  assign row_next = row_idx + 2'd1;
  assign cnt_inc  = cnt + CNT_ONE;

  // Scan / debounce FSM. The row index only moves while no key is owned,
  // so the held key's row stays driven through PRESS_DB, PRESSED and REL_DB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      row_out   <= 4'b1110;
      col_q     <= 2'd0;
      cnt       <= '0;
      kb_out    <= 4'hf;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (key_hit) begin
              col_q <= col_idx;
              if (SINGLE_TICK) begin
                cnt       <= CNT_MAX;
                kb_out    <= key_code(row_idx, col_idx);
                key_held  <= 1'b1;
                key_valid <= 1'b1;
                state     <= PRESSED;
              end else begin
                cnt   <= CNT_ONE;
                state <= PRESS_DB;
              end
            end else begin
              row_idx <= row_next;
              row_out <= row_drive(row_next);
            end
          end

          PRESS_DB: begin
            if (same_col) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                kb_out    <= key_code(row_idx, col_q);
                key_held  <= 1'b1;
                key_valid <= 1'b1;
                state     <= PRESSED;
              end
            end else begin
              cnt     <= '0;
              row_idx <= row_next;
              row_out <= row_drive(row_next);
              state   <= SCAN;
            end
          end

          PRESSED: begin
            // A second key in the same row reads as multi and starts a
            // release debounce; it bounces back here if the first stays down.
            if (!col_single) begin
              if (SINGLE_TICK) begin
                cnt      <= '0;
                kb_out   <= 4'hf;
                key_held <= 1'b0;
                row_idx  <= row_next;
                row_out  <= row_drive(row_next);
                state    <= SCAN;
              end else begin
                cnt   <= CNT_ONE;
                state <= REL_DB;
              end
            end
          end

          REL_DB: begin
            if (col_none) begin
              if (cnt_inc == CNT_MAX) begin
                cnt      <= '0;
                kb_out   <= 4'hf;
                key_held <= 1'b0;
                row_idx  <= row_next;
                row_out  <= row_drive(row_next);
                state    <= SCAN;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt   <= '0;
              state <= PRESSED;
            end
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
`timescale 1ns/1ps
// tb_keypad_scan_4x4
//   Directed bench for keypad_scan_4x4 with CLK_DIV=4, DEBOUNCE_CNT=3.
//   A small keypad model pulls a column low whenever a pressed key's row is
//   driven. Expected key codes are queued when a press is driven and popped
//   by a monitor on every key_valid pulse.
module tb_keypad_scan_4x4;

  localparam int CLK_DIV      = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] kb_out;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys_down;      // bit r*4+c set while key (r,c) is pressed
  int          ph;             // bench copy of the scan-tick phase
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  logic [3:0]  exp_q[$];
  logic        prev_valid = 1'b0;

  keypad_scan_4x4 #(
    .CLK_DIV      (CLK_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_in    (col_in),
    .row_out   (row_out),
    .kb_out    (kb_out),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its row line to its column line.
  always_comb begin
    col_in = 4'hf;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (keys_down[r*4 + c]) col_in[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (reset)                  ph <= 0;
    else if (ph == CLK_DIV - 1) ph <= 0;
    else                        ph <= ph + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Returns #1 after the n-th following scan-tick edge.
  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      while (ph != 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Returns at the negedge where key_valid is seen, or after max_clk.
  task automatic wait_valid(input string tag, input int max_clk);
    int k;
    k = 0;
    @(negedge clk);
    while (!key_valid && k < max_clk) begin
      @(negedge clk);
      k++;
    end
    check(tag, 8'(key_valid), 8'h01);
  endtask

  // Scoreboard monitor: every key_valid pops one expected code.
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      n_valid++;
      check("valid_pulse_width", 8'(prev_valid), 8'h00);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 8'(key_valid), 8'h00);
      end else begin
        check("valid_code", 8'(kb_out), 8'(exp_q.pop_front()));
        check("valid_held", 8'(key_held), 8'h01);
      end
    end
    prev_valid = key_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_row;
    logic [3:0] seq_code[6];
    int         seq_pos[6];
    int         k;

    seq_code = '{4'ha, 4'h2, 4'h0, 4'h1, 4'h8, 4'hc};
    seq_pos  = '{3, 1, 13, 0, 9, 11};

    // Reset, no key pressed.
    keys_down = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_row",   8'(row_out),   8'h0e);
    check("reset_kb",    8'(kb_out),    8'h0f);
    check("reset_valid", 8'(key_valid), 8'h00);
    check("reset_held",  8'(key_held),  8'h00);
    reset = 1'b0;

    // Idle scan: one row step every CLK_DIV clocks.
    for (int i = 0; i < 5; i++) begin
      exp_row = ~(4'b0001 << (i % 4));
      check($sformatf("scan_row%0d", i), 8'(row_out), 8'(exp_row));
      check($sformatf("scan_kb%0d", i),  8'(kb_out),  8'h0f);
      repeat (4) @(negedge clk);
    end

    // Key '8' (r2,c1): accept within 3 ticks + 2 clk of its row going active.
    tick_wait(1);
    keys_down[9] = 1'b1;
    exp_q.push_back(4'h8);
    k = 0;
    while (row_out != 4'b1011 && k < 32) begin
      @(posedge clk); #1; k++;
    end
    check("row2_reached", 8'(row_out), 8'h0b);
    k = 0;
    while (kb_out != 4'h8 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("key8_latency", 8'(k <= 14), 8'h01);
    check("key8_held",    8'(key_held), 8'h01);
    tick_wait(2);
    check("key8_level",   8'(kb_out), 8'h08);
    keys_down = '0;
    tick_wait(5);
    check("key8_release_kb",   8'(kb_out),   8'h0f);
    check("key8_release_held", 8'(key_held), 8'h00);

    // Bounce on '5' (r1,c1): toggle each tick for 4 ticks, then hold.
    k = 0;
    while (row_out != 4'b1101 && k < 32) begin
      @(posedge clk); #1; k++;
    end
    check("row1_reached", 8'(row_out), 8'h0d);
    for (int i = 0; i < 4; i++) begin
      keys_down[5] = (i % 2 == 0);
      tick_wait(1);
    end
    check("bounce_no_accept", 8'(kb_out), 8'h0f);
    keys_down[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_valid("key5_accept", 20);

    // Release bounce: 2 ticks up, 1 tick down, 3 ticks up.
    keys_down[5] = 1'b0;
    tick_wait(2);
    check("relb_after_2up", 8'(kb_out), 8'h05);
    keys_down[5] = 1'b1;
    tick_wait(1);
    check("relb_after_down", 8'(kb_out), 8'h05);
    keys_down[5] = 1'b0;
    tick_wait(2);
    check("relb_before_final", 8'(kb_out),   8'h05);
    check("relb_held",         8'(key_held), 8'h01);
    tick_wait(1);
    check("relb_final_kb",   8'(kb_out),   8'h0f);
    check("relb_final_held", 8'(key_held), 8'h00);

    // Two keys in row 0 (multi), then the reserved key: never accepted.
    keys_down[3] = 1'b1;
    keys_down[0] = 1'b1;
    tick_wait(10);
    check("multi_kb",   8'(kb_out),   8'h0f);
    check("multi_held", 8'(key_held), 8'h00);
    keys_down = '0;
    keys_down[15] = 1'b1;
    tick_wait(10);
    check("reserved_kb",   8'(kb_out),   8'h0f);
    check("reserved_held", 8'(key_held), 8'h00);
    keys_down = '0;
    tick_wait(2);

    // Sequence a,2,0,1,8,c.
    for (int i = 0; i < 6; i++) begin
      keys_down[seq_pos[i]] = 1'b1;
      exp_q.push_back(seq_code[i]);
      wait_valid($sformatf("seq%0d_accept", i), 40);
      tick_wait(5);
      check($sformatf("seq%0d_hold_kb", i),   8'(kb_out),   8'(seq_code[i]));
      check($sformatf("seq%0d_hold_held", i), 8'(key_held), 8'h01);
      keys_down = '0;
      tick_wait(5);
      check($sformatf("seq%0d_rel_kb", i),   8'(kb_out),   8'h0f);
      check($sformatf("seq%0d_rel_held", i), 8'(key_held), 8'h00);
    end

    // Reset while '8' is held, then re-detection after reset.
    keys_down[9] = 1'b1;
    exp_q.push_back(4'h8);
    wait_valid("prereset_accept", 40);
    tick_wait(1);
    check("prereset_kb", 8'(kb_out), 8'h08);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_kb",   8'(kb_out),   8'h0f);
    check("midreset_held", 8'(key_held), 8'h00);
    check("midreset_row",  8'(row_out),  8'h0e);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(4'h8);
    wait_valid("postreset_accept", 40);
    keys_down = '0;
    tick_wait(5);
    check("postreset_rel_kb", 8'(kb_out), 8'h0f);

    check("valid_count", 8'(n_valid),      8'd10);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
